axis_packet_arbiter: RTL and testbench
======================================

AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

Interface
REQ-001 Parameter NUM_SLAVES, default 4: number of slave AXIS inputs (2..16).
REQ-002 Parameter BUS_WIDTH, default 2: bytes per beat on every port.
REQ-003 Parameter USER_WIDTH, default 1: tuser width.
REQ-004 Parameter DEST_WIDTH, default 4: m_axis_tdest width; SHALL be >= clog2(NUM_SLAVES).
REQ-005 aclk  in  1  single clock; all logic rising-edge.
REQ-006 arst  in  1  reset, synchronous, active-high.
REQ-007 s_axis_tvalid  in  NUM_SLAVES  per-slave valid.
REQ-008 s_axis_tready  out  NUM_SLAVES  per-slave ready.
REQ-009 s_axis_tdata  in  NUM_SLAVES*BUS_WIDTH*8  packed slave data, slave 0 in LSBs.
REQ-010 s_axis_tkeep  in  NUM_SLAVES*BUS_WIDTH  packed byte enables.
REQ-011 s_axis_tlast  in  NUM_SLAVES  packet end per slave.
REQ-012 s_axis_tuser  in  NUM_SLAVES*USER_WIDTH  packed user.
REQ-013 m_axis_tvalid/tready/tdata/tkeep/tlast/tuser  out/in/out/out/out/out  1/1/BUS_WIDTH*8/BUS_WIDTH/1/USER_WIDTH  muxed master stream toward the width converter.
REQ-014 m_axis_tdest  out  DEST_WIDTH  index of granted slave, zero-extended.

Function
REQ-015 FSM states: IDLE, XFER.
REQ-016 IDLE: all s_axis_tready=0, m_axis_tvalid=0; if any s_axis_tvalid=1, register grant = first asserted index searching upward from pointer (wrapping), go XFER next cycle.
REQ-017 IDLE with no tvalid: stay IDLE, pointer unchanged.
REQ-018 XFER: m_axis_* = granted slave's signals combinationally; s_axis_tready[grant]=m_axis_tready; all other s_axis_tready=0.
REQ-019 Grant SHALL NOT change until a handshake (tvalid&tready) with tlast=1 on the granted slave.
REQ-020 On that tlast handshake: pointer <= (grant+1) mod NUM_SLAVES, state <= IDLE; one bubble cycle between packets.
REQ-021 Granted slave dropping tvalid mid-packet: stay XFER, m_axis_tvalid=0, grant held.
REQ-022 Latency (macro absent): first beat appears on master one cycle after request seen in IDLE; data path zero-cycle thereafter.
REQ-023 Fairness: with all slaves continuously requesting, grants SHALL cycle 0,1,..,NUM_SLAVES-1,0.
REQ-024 Requests from non-granted slaves during XFER SHALL be ignored until IDLE.

Reset
REQ-025 While arst=1: state=IDLE, pointer=0, grant=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdest=0, m_axis_tdata/tkeep/tuser=0.
REQ-026 Reset mid-packet SHALL abandon the packet; no partial-packet completion after reset release.

Configuration
REQ-027 Macro AXIS_ARB_OUT_REG_EN: when defined, a 2-entry skid buffer registers all m_axis_* outputs; m_axis_tready does not combinationally reach s_axis_tready; +1 cycle latency; full throughput kept.
REQ-028 Without AXIS_ARB_OUT_REG_EN: pure combinational mux in XFER per REQ-018.
REQ-029 With macro, FSM leaves XFER on tlast accepted into the skid buffer; buffer cleared by arst.

Structure
REQ-030 Package axis_arb_pkg: FSM state enum, function clog2, constant GRANT_WIDTH derivation.
REQ-031 One sub-module rr_priority_encoder: inputs request vector and pointer, output grant index and any-request flag; combinational.
REQ-032 Skid buffer inline under the macro; no further sub-modules.

Verification
REQ-033 NUM_SLAVES=4, only slave 2 sends 3-beat packet 0x1111,0x2222,0x3333(tlast) -> master outputs same beats, tdest=2, tlast on third, one cycle after request.
REQ-034 All 4 slaves hold 2-beat packets, m_axis_tready=1 -> packet order 0,1,2,3,0, one idle cycle between packets.
REQ-035 Slave 1 mid-packet, slave 0 requests -> slave 0 tready stays 0 until slave 1 tlast handshake; next grant is 2 if requesting else 3,0.
REQ-036 m_axis_tready toggled 1010 during packet -> no beat lost or duplicated; s_axis_tready[grant] mirrors m_axis_tready.
REQ-037 arst=1 for one cycle during beat 2 of 4 on slave 3 -> all outputs zero next cycle; after release, pointer=0, slave 0 wins if requesting.
REQ-038 AXIS_ARB_OUT_REG_EN defined, REQ-034 stimulus -> same data order, each first beat delayed one extra cycle, zero dropped beats under random tready.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared definitions for the AXI-Stream packet arbiter: FSM state
// encoding and the grant/pointer width derivation.
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // Upper bound on the number of slave ports the arbiter supports.
  localparam int MAX_SLAVES = 16;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Grant / pointer width: never narrower than one bit.
  function automatic int grant_width(input int num_slaves);
    return (clog2(num_slaves) < 1) ? 1 : clog2(num_slaves);
  endfunction

  localparam int GRANT_WIDTH_MAX = grant_width(MAX_SLAVES);

endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin priority encoder: picks the first asserted request at or
// above the pointer, wrapping past the top index back to zero.
module rr_priority_encoder #(
  parameter int NUM_REQ   = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   request,
  input  logic [PTR_WIDTH-1:0] pointer,
  output logic [PTR_WIDTH-1:0] grant,
  output logic                 any_request
);

  logic found;
  int   idx;

  // Scan NUM_REQ positions starting at the pointer; the first hit wins.
  always_comb begin
    grant       = '0;
    found       = 1'b0;
    idx         = 0;
    any_request = |request;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(pointer) + i) % NUM_REQ;
      if (!found && request[idx]) begin
        grant = PTR_WIDTH'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin arbiter merging NUM_SLAVES AXI-Stream inputs
// onto one master stream. A grant is held for a whole packet (until the
// tlast handshake) and one idle cycle separates consecutive packets.
// Optional macro AXIS_ARB_OUT_REG_EN inserts a 2-entry skid buffer that
// registers every m_axis_* output and breaks the m_axis_tready ->
// s_axis_tready combinational path (+1 cycle latency, full throughput).
module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int BUS_WIDTH  = 2,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 4
) (
  input  logic                              aclk,
  input  logic                              arst,
  input  logic [NUM_SLAVES-1:0]             s_axis_tvalid,
  output logic [NUM_SLAVES-1:0]             s_axis_tready,
  input  logic [NUM_SLAVES*BUS_WIDTH*8-1:0] s_axis_tdata,
  input  logic [NUM_SLAVES*BUS_WIDTH-1:0]   s_axis_tkeep,
  input  logic [NUM_SLAVES-1:0]             s_axis_tlast,
  input  logic [NUM_SLAVES*USER_WIDTH-1:0]  s_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [BUS_WIDTH*8-1:0]            m_axis_tdata,
  output logic [BUS_WIDTH-1:0]              m_axis_tkeep,
  output logic                              m_axis_tlast,
  output logic [USER_WIDTH-1:0]             m_axis_tuser,
  output logic [DEST_WIDTH-1:0]             m_axis_tdest
);

  localparam int GW    = grant_width(NUM_SLAVES);
  localparam int DW    = BUS_WIDTH * 8;
  localparam int PAY_W = DEST_WIDTH + USER_WIDTH + 1 + BUS_WIDTH + DW;

  arb_state_t      state_reg, state_next;
  logic [GW-1:0]   grant_reg, grant_next;
  logic [GW-1:0]   pointer_reg, pointer_next;
  logic [GW-1:0]   enc_grant;
  logic            enc_any;

  logic            xfer_active;
  logic            sel_valid;
  logic            sel_ready;
  logic            sel_last;
  logic [DW-1:0]   sel_data;
  logic [BUS_WIDTH-1:0]  sel_keep;
  logic [USER_WIDTH-1:0] sel_user;
  logic [DEST_WIDTH-1:0] sel_dest;
  logic [PAY_W-1:0]      sel_payload;
  logic            last_accept;

  rr_priority_encoder #(
    .NUM_REQ   (NUM_SLAVES),
    .PTR_WIDTH (GW)
  ) u_rr_priority_encoder (
    .request     (s_axis_tvalid),
    .pointer     (pointer_reg),
    .grant       (enc_grant),
    .any_request (enc_any)
  );

  // Reset forces the data path idle in the same cycle it is asserted.
  assign xfer_active = (state_reg == XFER) && !arst;

  // Select the granted slave's beat; everything reads as zero when idle.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    sel_user  = '0;
    sel_dest  = '0;
    if (xfer_active) begin
      sel_valid = s_axis_tvalid[grant_reg];
      sel_last  = s_axis_tlast[grant_reg];
      sel_data  = s_axis_tdata[int'(grant_reg)*DW +: DW];
      sel_keep  = s_axis_tkeep[int'(grant_reg)*BUS_WIDTH +: BUS_WIDTH];
      sel_user  = s_axis_tuser[int'(grant_reg)*USER_WIDTH +: USER_WIDTH];
      sel_dest  = DEST_WIDTH'(grant_reg);
    end
  end

  assign sel_payload = {sel_dest, sel_user, sel_last, sel_keep, sel_data};
  assign last_accept = sel_valid && sel_ready && sel_last;

  // Only the granted slave ever sees ready; other requesters wait for IDLE.
  always_comb begin
    s_axis_tready = '0;
    if (xfer_active) begin
      s_axis_tready[grant_reg] = sel_ready;
    end
  end

  // Next-state logic: grant latched in IDLE, released on the tlast handshake.
  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    pointer_next = pointer_reg;
    case (state_reg)
      IDLE: begin
        if (enc_any) begin
          grant_next = enc_grant;
          state_next = XFER;
        end
      end
      XFER: begin
        if (last_accept) begin
          pointer_next = (grant_reg == GW'(NUM_SLAVES - 1)) ? '0 : grant_reg + 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM, grant and round-robin pointer registers.
  always_ff @(posedge aclk) begin
    if (arst) begin
      state_reg   <= IDLE;
      grant_reg   <= '0;
      pointer_reg <= '0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      pointer_reg <= pointer_next;
    end
  end

`ifdef AXIS_ARB_OUT_REG_EN
  logic             out_valid_reg;
  logic [PAY_W-1:0] out_payload_reg;
  logic             skid_valid_reg;
  logic [PAY_W-1:0] skid_payload_reg;

  // Upstream may push whenever the skid slot is free; purely registered.
  assign sel_ready = !skid_valid_reg;

  // Two-entry skid buffer: output register plus one overflow slot.
  always_ff @(posedge aclk) begin
    if (arst) begin
      out_valid_reg    <= 1'b0;
      out_payload_reg  <= '0;
      skid_valid_reg   <= 1'b0;
      skid_payload_reg <= '0;
    end else if (!skid_valid_reg) begin
      if (!out_valid_reg || m_axis_tready) begin
        out_valid_reg <= sel_valid;
        if (sel_valid) begin
          out_payload_reg <= sel_payload;
        end
      end else if (sel_valid) begin
        skid_valid_reg   <= 1'b1;
        skid_payload_reg <= sel_payload;
      end
    end else if (m_axis_tready) begin
      out_valid_reg   <= 1'b1;
      out_payload_reg <= skid_payload_reg;
      skid_valid_reg  <= 1'b0;
    end
  end

  assign m_axis_tvalid = out_valid_reg;
  assign {m_axis_tdest, m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = out_payload_reg;
`else
  // Pass-through: downstream ready goes straight back to the granted slave.
  assign sel_ready     = m_axis_tready;
  assign m_axis_tvalid = sel_valid;
  assign {m_axis_tdest, m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = sel_payload;
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Self-checking bench for axis_packet_arbiter (4 slaves, 2-byte beats).
// Slaves are fed from per-slave beat queues; the expected master stream is
// assembled from hand-specified packet orders and checked beat by beat.
module tb_axis_packet_arbiter;

  localparam int NS = 4;
`ifdef AXIS_ARB_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  typedef struct packed {
    logic [3:0] dest;
    beat_t      beat;
  } exp_t;

  typedef struct {
    int          cyc;
    int          dest;
    logic [15:0] data;
    logic        last;
  } log_t;

  typedef struct {
    int   cyc;
    int   slave;
    logic last;
  } slog_t;

  logic            clk = 1'b0;
  logic            arst = 1'b1;
  logic [NS-1:0]   s_tvalid = '0;
  logic [NS-1:0]   s_tready;
  logic [NS*16-1:0] s_tdata = '0;
  logic [NS*2-1:0] s_tkeep = '0;
  logic [NS-1:0]   s_tlast = '0;
  logic [NS-1:0]   s_tuser = '0;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic [15:0]     m_tdata;
  logic [1:0]      m_tkeep;
  logic            m_tlast;
  logic            m_tuser;
  logic [3:0]      m_tdest;

  beat_t slave_q [NS][$];
  beat_t exp_src [NS][$];
  exp_t  exp_q [$];
  log_t  hs_log [$];
  slog_t s_log [$];

  logic [NS-1:0] en = '1;
  logic [NS-1:0] hs_s = '0;
  int cyc = 0;
  int first_req_cyc = -1;
  int n_checks = 0;
  int n_fail = 0;
  int ready_mode = 0;
  int pkt_id = 0;
  int pops [NS];

  always #5 clk = ~clk;

  axis_packet_arbiter #(
    .NUM_SLAVES (NS),
    .BUS_WIDTH  (2),
    .USER_WIDTH (1),
    .DEST_WIDTH (4)
  ) dut (
    .aclk          (clk),
    .arst          (arst),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .m_axis_tdest  (m_tdest)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present each slave's queue head (if enabled) on its input lanes.
  task automatic drive_slaves();
    for (int i = 0; i < NS; i++) begin
      if (!arst && en[i] && slave_q[i].size() > 0) begin
        s_tvalid[i]         = 1'b1;
        s_tdata[i*16 +: 16] = slave_q[i][0].data;
        s_tkeep[i*2 +: 2]   = slave_q[i][0].keep;
        s_tlast[i]          = slave_q[i][0].last;
        s_tuser[i]          = slave_q[i][0].user;
      end else begin
        s_tvalid[i]         = 1'b0;
        s_tdata[i*16 +: 16] = '0;
        s_tkeep[i*2 +: 2]   = '0;
        s_tlast[i]          = 1'b0;
        s_tuser[i]          = 1'b0;
      end
    end
  endtask

  // Advance one clock: retire accepted slave beats, update ready, redrive.
  task automatic tick();
    beat_t tmp;
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (hs_s[i]) begin
        tmp = slave_q[i].pop_front();
        pops[i]++;
      end
    end
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
    drive_slaves();
  endtask

  task automatic load_beat(input int s, input logic [15:0] d, input logic [1:0] k,
                           input logic l, input logic u);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    b.user = u;
    slave_q[s].push_back(b);
    exp_src[s].push_back(b);
  endtask

  task automatic load_pkt(input int s, input int n);
    logic [15:0] d;
    for (int b = 0; b < n; b++) begin
      d = {4'(s), 4'(pkt_id), 8'(b + 1)};
      load_beat(s, d, (b == n - 1) ? 2'b01 : 2'b11, b == n - 1, 1'(b));
    end
    pkt_id++;
  endtask

  // Append the next packet of slave s to the expected master stream.
  task automatic expect_pkt(input int s);
    exp_t  e;
    beat_t b;
    b.last = 1'b0;
    while (!b.last && exp_src[s].size() > 0) begin
      b      = exp_src[s].pop_front();
      e.dest = 4'(s);
      e.beat = b;
      exp_q.push_back(e);
    end
  endtask

  function automatic int pending();
    int n;
    n = 0;
    for (int i = 0; i < NS; i++) n += slave_q[i].size();
    return n;
  endfunction

  task automatic reset_pulse();
    arst = 1'b1;
    for (int i = 0; i < NS; i++) begin
      slave_q[i].delete();
      exp_src[i].delete();
    end
    exp_q.delete();
    drive_slaves();
    tick();
    arst = 1'b0;
    drive_slaves();
  endtask

  task automatic start_test();
    hs_log.delete();
    s_log.delete();
    first_req_cyc = -1;
    for (int i = 0; i < NS; i++) pops[i] = 0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pending() != 0) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_expected_left"}, exp_q.size(), 0);
    check({name, "_slave_beats_left"}, pending(), 0);
    repeat (3) tick();
  endtask

  // Per-cycle compare: protocol invariants plus the beat scoreboard.
  initial begin
    exp_t e_cur;
    log_t lt;
    slog_t st;
    forever begin
      @(negedge clk);
      cyc++;
      hs_s = s_tvalid & s_tready;
      if (!arst) begin
        if (first_req_cyc < 0 && |s_tvalid) first_req_cyc = cyc;
`ifndef AXIS_ARB_OUT_REG_EN
        if (m_tvalid) begin
          check("ready_mirror", s_tready, m_tready ? (4'b0001 << m_tdest) : 4'b0000);
          check("src_valid", s_tvalid[m_tdest], 1);
        end else begin
          check("ready_idle", s_tready & ~(4'b0001 << m_tdest), 0);
        end
`endif
        check("ready_onehot", $countones(s_tready) <= 1, 1);
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got dest=%0d data=%h expected none (cycle %0d)",
                     m_tdest, m_tdata, cyc);
          end else begin
            e_cur = exp_q.pop_front();
            check("beat", {m_tdest, m_tdata, m_tkeep, m_tlast, m_tuser}, e_cur);
          end
          lt.cyc  = cyc;
          lt.dest = int'(m_tdest);
          lt.data = m_tdata;
          lt.last = m_tlast;
          hs_log.push_back(lt);
          $display("beat cyc=%0d dest=%0d data=%h keep=%b last=%0b user=%0b",
                   cyc, m_tdest, m_tdata, m_tkeep, m_tlast, m_tuser);
        end
        for (int i = 0; i < NS; i++) begin
          if (hs_s[i]) begin
            st.cyc   = cyc;
            st.slave = i;
            st.last  = s_tlast[i];
            s_log.push_back(st);
          end
        end
      end
    end
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int l1, f0, f3, n1;
    for (int i = 0; i < NS; i++) pops[i] = 0;
    drive_slaves();
    repeat (3) tick();
    @(negedge clk);
    check("reset_state", {s_tready, m_tvalid, m_tlast, m_tdest, m_tdata, m_tkeep, m_tuser}, 0);
    tick();
    arst = 1'b0;
    drive_slaves();
    tick();

    // T1: lone 3-beat packet from slave 2.
    start_test();
    load_beat(2, 16'h1111, 2'b11, 1'b0, 1'b0);
    load_beat(2, 16'h2222, 2'b11, 1'b0, 1'b1);
    load_beat(2, 16'h3333, 2'b11, 1'b1, 1'b0);
    expect_pkt(2);
    drive_slaves();
    wait_drain("t1", 50);
    check("t1_beats", hs_log.size(), 3);
    if (hs_log.size() >= 3) begin
      check("t1_first_data", hs_log[0].data, 16'h1111);
      check("t1_third_data", hs_log[2].data, 16'h3333);
      check("t1_dest", hs_log[0].dest, 2);
      check("t1_last_flags", {hs_log[0].last, hs_log[1].last, hs_log[2].last}, 3'b001);
      check("t1_latency", hs_log[0].cyc - first_req_cyc, LAT);
    end

    // T2: all slaves hold 2-beat packets, slave 0 has a second one.
    start_test();
    reset_pulse();
    load_pkt(0, 2);
    load_pkt(1, 2);
    load_pkt(2, 2);
    load_pkt(3, 2);
    load_pkt(0, 2);
    expect_pkt(0);
    expect_pkt(1);
    expect_pkt(2);
    expect_pkt(3);
    expect_pkt(0);
    drive_slaves();
    wait_drain("t2", 100);
    check("t2_beats", hs_log.size(), 10);
    if (hs_log.size() >= 10) begin
      check("t2_latency", hs_log[0].cyc - first_req_cyc, LAT);
      for (int k = 0; k < 5; k++) begin
        check("t2_intra_gap", hs_log[2*k+1].cyc - hs_log[2*k].cyc, 1);
        if (k > 0) check("t2_bubble_gap", hs_log[2*k].cyc - hs_log[2*k-1].cyc, 2);
      end
    end

    // T3: slave 1 mid-packet (with a valid gap) while slaves 0 and 3 request.
    start_test();
    reset_pulse();
    load_pkt(1, 4);
    expect_pkt(1);
    drive_slaves();
    tick();
    tick();
    en[1] = 1'b0;
    load_pkt(0, 2);
    load_pkt(3, 2);
    expect_pkt(3);
    expect_pkt(0);
    drive_slaves();
    tick();
    tick();
    en[1] = 1'b1;
    drive_slaves();
    wait_drain("t3", 100);
    l1 = -1;
    f0 = -1;
    f3 = -1;
    n1 = 0;
    foreach (s_log[k]) begin
      if (s_log[k].slave == 1) n1++;
      if (s_log[k].slave == 1 && s_log[k].last) l1 = s_log[k].cyc;
      if (s_log[k].slave == 0 && f0 < 0) f0 = s_log[k].cyc;
      if (s_log[k].slave == 3 && f3 < 0) f3 = s_log[k].cyc;
    end
    check("t3_slave1_beats", n1, 4);
    check("t3_slave3_after_slave1", f3 > l1, 1);
    check("t3_slave0_after_slave3", f0 > f3, 1);

    // T4: toggling ready, then random ready across all slaves.
    start_test();
    reset_pulse();
    ready_mode = 1;
    load_pkt(0, 4);
    load_pkt(1, 3);
    expect_pkt(0);
    expect_pkt(1);
    drive_slaves();
    wait_drain("t4_toggle", 100);
    ready_mode = 2;
    for (int i = 0; i < NS; i++) load_pkt(i, 3);
    expect_pkt(2);
    expect_pkt(3);
    expect_pkt(0);
    expect_pkt(1);
    drive_slaves();
    wait_drain("t4_random", 300);
    ready_mode = 0;
    check("t4_beats", hs_log.size(), 19);

    // T5: reset during beat 2 of 4 on slave 3, pointer previously at 2.
    start_test();
    reset_pulse();
    load_pkt(1, 2);
    expect_pkt(1);
    drive_slaves();
    wait_drain("t5_pre", 50);
    load_pkt(3, 4);
    expect_pkt(3);
    drive_slaves();
    for (int i = 0; i < NS; i++) pops[i] = 0;
    for (int n = 0; n < 20 && pops[3] < 1; n++) tick();
    check("t5_started", pops[3], 1);
    reset_pulse();
    @(negedge clk);
    check("t5_reset_outputs", {s_tready, m_tvalid, m_tlast, m_tdest, m_tdata, m_tkeep, m_tuser}, 0);
    tick();
    start_test();
    load_pkt(3, 2);
    load_pkt(0, 2);
    expect_pkt(0);
    expect_pkt(3);
    drive_slaves();
    wait_drain("t5_post", 50);
    check("t5_beats", hs_log.size(), 4);
    if (hs_log.size() >= 1) check("t5_first_dest", hs_log[0].dest, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
